// File: rtl/serializer_gearbox.sv
// Multi-channel parallel-to-serial gearbox with one-word hold buffer, word-boundary marker and idle fill.
// Optional macro SERIALIZER_MSB_FIRST_EN selects MSB-first slice order (default LSB-first).
module serializer_gearbox #(
    parameter int                CHANNELS  = 3,
    parameter int                DATA_W    = 10,
    parameter int                OUT_W     = 2,
    parameter logic [DATA_W-1:0] IDLE_WORD = 10'b1101010100
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [CHANNELS*DATA_W-1:0]   in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [CHANNELS*OUT_W-1:0]    out_data,
    output logic                         out_first,
    output logic                         underrun
);
    localparam int BEATS = DATA_W / OUT_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    generate
        if (DATA_W % OUT_W != 0) begin : g_bad_ratio
            $error("serializer_gearbox: DATA_W must be a multiple of OUT_W");
        end
    endgenerate

    typedef enum logic {
        STARTUP,
        RUN
    } state_t;

    state_t                       state;
    state_t                       state_next;
    logic [CNT_W-1:0]             beat_cnt;
    logic [CHANNELS*DATA_W-1:0]   hold_reg;
    logic                         hold_full;
    logic                         load_now;
    logic                         accept;
    logic                         underrun_next;

    assign load_now = (beat_cnt == CNT_W'(BEATS - 1));
    assign in_ready = !hold_full || load_now;
    assign accept   = in_valid && in_ready;

    // Underrun only counts once real traffic has started; startup idle fill is expected.
    always_comb begin
        state_next    = state;
        underrun_next = 1'b0;
        if (load_now) begin
            if (hold_full) begin
                state_next = RUN;
            end else if (state == RUN) begin
                underrun_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= STARTUP;
            underrun <= 1'b0;
        end else begin
            state    <= state_next;
            underrun <= underrun_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt  <= '0;
            out_first <= 1'b1;
        end else if (load_now) begin
            beat_cnt  <= '0;
            out_first <= 1'b1;
        end else begin
            beat_cnt  <= beat_cnt + 1'b1;
            out_first <= 1'b0;
        end
    end

    // A word accepted on a load edge refills the hold while the old one moves to the shifters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_reg  <= '0;
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_reg  <= in_data;
            hold_full <= 1'b1;
        end else if (load_now) begin
            hold_full <= 1'b0;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        logic [DATA_W-1:0] shift_q;
        logic [DATA_W-1:0] shifted;

        if (BEATS > 1) begin : g_shift
`ifdef SERIALIZER_MSB_FIRST_EN
            assign shifted = {shift_q[DATA_W-OUT_W-1:0], {OUT_W{1'b0}}};
`else
            assign shifted = {{OUT_W{1'b0}}, shift_q[DATA_W-1:OUT_W]};
`endif
        end else begin : g_noshift
            assign shifted = shift_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                shift_q <= IDLE_WORD;
            end else if (load_now) begin
                shift_q <= hold_full ? hold_reg[c*DATA_W +: DATA_W] : IDLE_WORD;
            end else begin
                shift_q <= shifted;
            end
        end

`ifdef SERIALIZER_MSB_FIRST_EN
        assign out_data[c*OUT_W +: OUT_W] = shift_q[DATA_W-1 -: OUT_W];
`else
        assign out_data[c*OUT_W +: OUT_W] = shift_q[OUT_W-1:0];
`endif
    end

endmodule

// File: tb/tb_serializer_gearbox.sv
// Directed bench for serializer_gearbox: idle fill, single word, streaming, backpressure, mid-word reset.
// Honours SERIALIZER_MSB_FIRST_EN for the expected slice order.
module tb_serializer_gearbox;
    localparam int                CHANNELS  = 3;
    localparam int                DATA_W    = 10;
    localparam int                OUT_W     = 2;
    localparam int                BEATS     = 5;
    localparam logic [DATA_W-1:0] IDLE_WORD = 10'b1101010100;

    logic                         clk      = 1'b0;
    logic                         rst_n    = 1'b0;
    logic [CHANNELS*DATA_W-1:0]   in_data  = '0;
    logic                         in_valid = 1'b0;
    logic                         in_ready;
    logic [CHANNELS*OUT_W-1:0]    out_data;
    logic                         out_first;
    logic                         underrun;

    int compared   = 0;
    int mismatched = 0;

    // Stream-level reference: words waiting to be sent, word on the wire, beat position.
    logic [CHANNELS*DATA_W-1:0] pend_q[$];
    logic [CHANNELS*DATA_W-1:0] cur_words;
    int                         phase;
    logic                       started;
    logic                       exp_underrun;

    int idle_tab[5];
    int word_tab[5];

    always #5 clk = ~clk;

    serializer_gearbox #(
        .CHANNELS (CHANNELS),
        .DATA_W   (DATA_W),
        .OUT_W    (OUT_W),
        .IDLE_WORD(IDLE_WORD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_first(out_first),
        .underrun (underrun)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [OUT_W-1:0] slice_of(input logic [DATA_W-1:0] w, input int k);
`ifdef SERIALIZER_MSB_FIRST_EN
        return w[DATA_W-1-k*OUT_W -: OUT_W];
`else
        return w[k*OUT_W +: OUT_W];
`endif
    endfunction

    function automatic logic [CHANNELS*OUT_W-1:0] expected_out();
        logic [CHANNELS*OUT_W-1:0] r;
        r = '0;
        for (int c = 0; c < CHANNELS; c++)
            r[c*OUT_W +: OUT_W] = slice_of(cur_words[c*DATA_W +: DATA_W], phase);
        return r;
    endfunction

    task automatic doReset();
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        pend_q.delete();
        cur_words    = {CHANNELS{IDLE_WORD}};
        phase        = 0;
        started      = 1'b0;
        exp_underrun = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_data", 32'(out_data), 32'(expected_out()));
        checkOutput("rst_out_first", 32'(out_first), 32'd1);
        checkOutput("rst_underrun", 32'(underrun), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
    endtask

    // One clock: present inputs, check handshake, advance the reference, check outputs.
    task automatic applyStimulus(input logic v, input logic [CHANNELS*DATA_W-1:0] d, output bit acc);
        in_valid = v;
        in_data  = d;
        #1;
        checkOutput("in_ready", 32'(in_ready), 32'(pend_q.size() == 0 || phase == BEATS - 1));
        acc = v && in_ready;
        @(posedge clk);
        #1;
        if (phase == BEATS - 1) begin
            phase = 0;
            if (pend_q.size() > 0) begin
                cur_words    = pend_q.pop_front();
                started      = 1'b1;
                exp_underrun = 1'b0;
            end else begin
                cur_words    = {CHANNELS{IDLE_WORD}};
                exp_underrun = started;
            end
        end else begin
            phase++;
            exp_underrun = 1'b0;
        end
        if (acc) pend_q.push_back(d);
        checkOutput("out_data", 32'(out_data), 32'(expected_out()));
        checkOutput("out_first", 32'(out_first), 32'(phase == 0));
        checkOutput("underrun", 32'(underrun), 32'(exp_underrun));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit acc;
        bit done;
        logic [CHANNELS*DATA_W-1:0] word;
        int tries;

`ifdef SERIALIZER_MSB_FIRST_EN
        idle_tab = '{3, 1, 1, 1, 0};
        word_tab = '{3, 1, 0, 3, 2};
`else
        idle_tab = '{0, 1, 1, 1, 3};
        word_tab = '{2, 3, 0, 1, 3};
`endif

        $display("[TB] reset then idle");
        doReset();
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(1'b0, '0, acc);
            checkOutput("idle_ch0_slice", 32'(out_data[1:0]), 32'(idle_tab[k % 5]));
            checkOutput("idle_ch2_slice", 32'(out_data[5:4]), 32'(idle_tab[k % 5]));
        end

        $display("[TB] single word 0x34E");
        doReset();
        applyStimulus(1'b1, {CHANNELS{10'h34E}}, acc);
        checkOutput("single_accepted", 32'(acc), 32'd1);
        repeat (3) applyStimulus(1'b0, '0, acc);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, '0, acc);
            checkOutput("word_ch2_slice", 32'(out_data[5:4]), 32'(word_tab[k]));
            if (k == 0) checkOutput("word_first", 32'(out_first), 32'd1);
        end
        applyStimulus(1'b0, '0, acc);
        checkOutput("word_underrun_pulse", 32'(underrun), 32'd1);
        checkOutput("word_idle_after", 32'(out_data[1:0]), 32'(idle_tab[0]));
        applyStimulus(1'b0, '0, acc);
        checkOutput("word_underrun_drop", 32'(underrun), 32'd0);

        $display("[TB] mid-word reset");
        doReset();
        applyStimulus(1'b1, {10'h2A7, 10'h0F1, 10'h155}, acc);
        repeat (6) applyStimulus(1'b0, '0, acc);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_data", 32'(out_data), 32'({CHANNELS{slice_of(IDLE_WORD, 0)}}));
        checkOutput("midrst_out_first", 32'(out_first), 32'd1);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        doReset();
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(1'b0, '0, acc);
            checkOutput("midrst_idle_ch1", 32'(out_data[3:2]), 32'(idle_tab[k % 5]));
        end

        $display("[TB] back-to-back stream");
        for (int i = 0; i < 100; i++) begin
            word = (CHANNELS*DATA_W)'({$urandom, $urandom});
            done = 1'b0;
            tries = 0;
            while (!done && tries < 10) begin
                applyStimulus(1'b1, word, acc);
                done = acc;
                tries++;
            end
            if (!done) checkOutput("stream_accept_timeout", 32'd0, 32'd1);
        end

        $display("[TB] backpressure");
        for (int i = 0; i < 60; i++) begin
            word = (CHANNELS*DATA_W)'({$urandom, $urandom});
            done = 1'b0;
            tries = 0;
            while (!done && tries < 50) begin
                if ($urandom_range(0, 1) == 1) begin
                    applyStimulus(1'b1, word, acc);
                    done = acc;
                end else begin
                    applyStimulus(1'b0, (CHANNELS*DATA_W)'({$urandom, $urandom}), acc);
                end
                tries++;
            end
            if (!done) checkOutput("bp_accept_timeout", 32'd0, 32'd1);
        end

        repeat (12) applyStimulus(1'b0, '0, acc);
        checkOutput("drain_empty", 32'(pend_q.size()), 32'd0);

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
